beta_prefetch_buffer: RTL and testbench
=======================================

BETA_PREFETCH_BUFFER -- requirements
Module: beta_prefetch_buffer

Interface
REQ-001 Parameter DataWidth, default 32, width of address and instruction data lines.
REQ-002 Parameter Depth, default 4, FIFO entries; power of two, >= 2.
REQ-003 Parameter BootAddr, default 32'h0000_0000, fetch address loaded at reset.
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 pf_fetch_en_i  in  1  allows new memory requests to be issued.
REQ-007 pf_instr_req_o  out  1  request to instruction memory.
REQ-008 pf_instr_addr_o  out  DataWidth  word-aligned request address.
REQ-009 pf_instr_ready_i  in  1  memory accepts request this cycle (grant).
REQ-010 pf_instr_valid_i  in  1  memory returns one in-order response.
REQ-011 pf_instr_rdata_i  in  DataWidth  response data.
REQ-012 pf_flush_i  in  1  redirect: discard buffered/in-flight instructions.
REQ-013 pf_flush_pc_i  in  DataWidth  new fetch address on flush.
REQ-014 pf_valid_o  out  1  head entry available to fetch stage.
REQ-015 pf_instr_o / pf_pc_o  out  DataWidth each  head instruction and its address.
REQ-016 pf_pop_i  in  1  fetch stage consumes head; ignored when pf_valid_o low.
REQ-017 pf_busy_o  out  1  high while any request is outstanding.

Function
REQ-018 Request issued (pf_instr_req_o=1) iff pf_fetch_en_i & !pf_flush_i & (fifo_count + outstanding) < Depth.
REQ-019 Handshake: request completes on req & ready; pf_instr_addr_o held stable until granted; then address += 4.
REQ-020 Outstanding counter: +1 on grant, -1 on response; range 0..Depth; both same cycle -> unchanged.
REQ-021 Response (pf_instr_valid_i) pushes {rdata, pc} into FIFO; pc tracked by a response-address register advanced by 4 per push.
REQ-022 Credit rule guarantees no push into full FIFO; push and pop in same cycle on full FIFO legal, count unchanged.
REQ-023 Pop on empty FIFO: no effect; pf_valid_o = (count != 0).
REQ-024 Pointers wrap modulo Depth.
REQ-025 Flush: FIFO count <= 0, request address and response-address <= pf_flush_pc_i, discard counter <= outstanding minus any response in flush cycle.
REQ-026 While discard counter > 0, responses decrement it and are not pushed; new requests may issue after flush cycle; no request issued in flush cycle.
REQ-027 Flush and pop same cycle: flush wins. Flush and grant same cycle impossible per REQ-018.
REQ-028 Request address low two bits always 0; pf_flush_pc_i low bits ignored (forced 0).
REQ-029 Latency (macro off): response at cycle N -> pf_valid_o high cycle N+1.
REQ-030 pf_fetch_en_i low: no new requests; in-flight responses still accepted and buffered.

Reset
REQ-031 On rst_i: count, pointers, outstanding, discard counter = 0; request and response address = BootAddr.
REQ-032 Outputs after reset: pf_instr_req_o=0 until fetch_en, pf_valid_o=0, pf_busy_o=0, pf_instr_o=0, pf_pc_o=BootAddr.
REQ-033 Reset mid-transaction drops in-flight responses; memory is reset concurrently by the system.

Configuration
REQ-034 Macro BETA_PF_BYPASS_EN defined: when FIFO empty and a non-discarded response arrives, pf_valid_o/pf_instr_o/pf_pc_o reflect it combinationally the same cycle; if popped that cycle it is not stored.
REQ-035 Macro undefined: no combinational path from memory response to pf_* outputs; latency per REQ-029.

Structure
REQ-036 beta_pkg holds PF_DEPTH_DEFAULT (4), INSTR_BYTES (4) and typedef pf_entry_t {instr, pc}.
REQ-037 Storage in sub-module beta_pf_fifo (push, pop, flush, full, empty, count); control, counters and addressing in top.

Verification
REQ-038 Reset, fetch_en=1, ready=1, valid one cycle after grant, no pop -> exactly 4 grants (0x0,0x4,0x8,0xC), req drops, pf_valid_o=1, pf_pc_o=0x0.
REQ-039 Full FIFO, pop every cycle with ready=1 -> one grant per cycle, pf_pc_o sequence 0x0,0x4,0x8..., no overflow, no lost entry.
REQ-040 Two requests outstanding, pf_flush_i with pf_flush_pc_i=0x100 -> both late responses discarded, next pf_pc_o=0x100, first new address 0x100.
REQ-041 ready=0 for 3 cycles with req high -> pf_instr_addr_o stable, outstanding unchanged; grant on 4th cycle.
REQ-042 Macro on, empty FIFO, response 0xDEADBEEF with pop same cycle -> pf_valid_o=1 same cycle, count stays 0; macro off -> pf_valid_o next cycle.
REQ-043 rst_i asserted with 2 outstanding -> next cycle all counters 0, pf_busy_o=0, pf_valid_o=0, address=BootAddr.

Source files
------------

// File: rtl/beta_pkg.sv
// Shared constants and the buffered entry type for the instruction prefetch buffer.
package beta_pkg;
  localparam int PF_DEPTH_DEFAULT = 4;
  localparam int INSTR_BYTES      = 4;
  localparam int PF_XLEN          = 32;

  typedef struct packed {
    logic [PF_XLEN-1:0] instr;
    logic [PF_XLEN-1:0] pc;
  } pf_entry_t;
endpackage

// File: rtl/beta_prefetch_buffer_if.sv
// Memory-side and fetch-side handshake bundle of the prefetch buffer.
interface beta_prefetch_buffer_if #(parameter int DataWidth = 32);
  logic                 pf_fetch_en_i;
  logic                 pf_instr_req_o;
  logic [DataWidth-1:0] pf_instr_addr_o;
  logic                 pf_instr_ready_i;
  logic                 pf_instr_valid_i;
  logic [DataWidth-1:0] pf_instr_rdata_i;
  logic                 pf_flush_i;
  logic [DataWidth-1:0] pf_flush_pc_i;
  logic                 pf_valid_o;
  logic [DataWidth-1:0] pf_instr_o;
  logic [DataWidth-1:0] pf_pc_o;
  logic                 pf_pop_i;
  logic                 pf_busy_o;

  modport master (
    input  pf_fetch_en_i, pf_instr_ready_i, pf_instr_valid_i, pf_instr_rdata_i,
           pf_flush_i, pf_flush_pc_i, pf_pop_i,
    output pf_instr_req_o, pf_instr_addr_o, pf_valid_o, pf_instr_o, pf_pc_o, pf_busy_o
  );

  modport slave (
    output pf_fetch_en_i, pf_instr_ready_i, pf_instr_valid_i, pf_instr_rdata_i,
           pf_flush_i, pf_flush_pc_i, pf_pop_i,
    input  pf_instr_req_o, pf_instr_addr_o, pf_valid_o, pf_instr_o, pf_pc_o, pf_busy_o
  );
endinterface

// File: rtl/beta_pf_fifo.sv
// Power-of-two entry FIFO holding {instr, pc}; flush empties it in one cycle.
module beta_pf_fifo
  import beta_pkg::*;
#(
  parameter int Depth = PF_DEPTH_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  pf_entry_t                wdata,
  output pf_entry_t                rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);
  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;

  pf_entry_t      mem [Depth];
  logic [AW-1:0]  wptr, rptr;
  logic           do_pop;

  assign empty  = (count == '0);
  assign full   = (count == CW'(Depth));
  assign do_pop = pop & ~empty;
  assign rdata  = mem[rptr];

  // Pointers are AW bits wide, so they wrap modulo Depth on their own.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)   wptr <= wptr + AW'(1);
      if (do_pop) rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/beta_prefetch_buffer.sv
// Instruction prefetch buffer: credit-limited request issue, flush discard, in-order FIFO.
// Define BETA_PF_BYPASS_EN to forward a response straight to the outputs when the FIFO is empty.
module beta_prefetch_buffer
  import beta_pkg::*;
#(
  parameter int                   DataWidth = 32,
  parameter int                   Depth     = PF_DEPTH_DEFAULT,
  parameter logic [DataWidth-1:0] BootAddr  = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  beta_prefetch_buffer_if.master  bus
);
  localparam int CW = $clog2(Depth) + 1;

  function automatic logic [DataWidth-1:0] word_align(input logic [DataWidth-1:0] a);
    return a & ~DataWidth'(3);
  endfunction

  logic [DataWidth-1:0] req_addr, resp_addr;
  logic [CW-1:0]        outstanding, discard, fifo_count;
  logic [CW:0]          credit;
  logic                 fifo_full, fifo_empty;
  logic                 grant, resp, keep, bypass, push, pop;
  pf_entry_t            head, entry;

  // Every slot, filled or in flight, counts against the FIFO depth.
  assign credit              = {1'b0, fifo_count} + {1'b0, outstanding};
  assign bus.pf_instr_req_o  = bus.pf_fetch_en_i & ~bus.pf_flush_i & (credit < (CW+1)'(Depth));
  assign bus.pf_instr_addr_o = req_addr;
  assign bus.pf_busy_o       = (outstanding != '0);

  assign grant = bus.pf_instr_req_o & bus.pf_instr_ready_i;
  assign resp  = bus.pf_instr_valid_i;
  assign keep  = resp & ~bus.pf_flush_i & (discard == '0);
  assign pop   = bus.pf_pop_i & ~bus.pf_flush_i;

`ifdef BETA_PF_BYPASS_EN
  assign bypass = keep & fifo_empty;
  assign push   = keep & ~(bypass & bus.pf_pop_i) & (~fifo_full | pop);
`else
  assign bypass = 1'b0;
  assign push   = keep & (~fifo_full | pop);
`endif

  assign entry.instr = bus.pf_instr_rdata_i;
  assign entry.pc    = resp_addr;

  beta_pf_fifo #(.Depth(Depth)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (pop),
    .flush (bus.pf_flush_i),
    .wdata (entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.pf_valid_o = ~fifo_empty | bypass;

  // With nothing buffered, pc shows the address the next response will carry.
  always_comb begin
    bus.pf_instr_o = '0;
    bus.pf_pc_o    = resp_addr;
    if (!fifo_empty) begin
      bus.pf_instr_o = head.instr;
      bus.pf_pc_o    = head.pc;
    end else if (bypass) begin
      bus.pf_instr_o = bus.pf_instr_rdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding <= '0;
      discard     <= '0;
      req_addr    <= word_align(BootAddr);
      resp_addr   <= word_align(BootAddr);
    end else begin
      outstanding <= outstanding + CW'(grant) - CW'(resp);
      if (bus.pf_flush_i) begin
        discard   <= outstanding - CW'(resp);
        req_addr  <= word_align(bus.pf_flush_pc_i);
        resp_addr <= word_align(bus.pf_flush_pc_i);
      end else begin
        if (resp && discard != '0) discard <= discard - CW'(1);
        if (grant) req_addr  <= req_addr + DataWidth'(INSTR_BYTES);
        if (keep)  resp_addr <= resp_addr + DataWidth'(INSTR_BYTES);
      end
    end
  end
endmodule

// File: tb/tb_beta_prefetch_buffer.sv
// Directed and random stimulus against a queue-based model of the prefetch buffer.
module tb_beta_prefetch_buffer;
  import beta_pkg::*;

  localparam int          DW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BOOT  = 32'h0000_0000;
`ifdef BETA_PF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  beta_prefetch_buffer_if #(.DataWidth(DW)) bus ();

  beta_prefetch_buffer #(.DataWidth(DW), .Depth(DEPTH), .BootAddr(BOOT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct { logic [31:0] addr; bit disc; } flight_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

  flight_t     infl[$];
  ent_t        fq[$];
  logic [31:0] nxt;
  logic [31:0] pop_pc;
  int          total = 0;
  int          bad   = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit fe, input bit rdy, input bit vld, input bit fl,
                       input logic [31:0] fpc, input bit pop);
    bus.pf_fetch_en_i    = fe;
    bus.pf_instr_ready_i = rdy;
    bus.pf_instr_valid_i = vld;
    bus.pf_instr_rdata_i = vld ? mem_data(infl[0].addr) : $urandom;
    bus.pf_flush_i       = fl;
    bus.pf_flush_pc_i    = fpc;
    bus.pf_pop_i         = pop;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    infl.delete();
    fq.delete();
    nxt    = BOOT;
    pop_pc = BOOT;
    @(negedge clk);
    chk("rst_req",   32'(bus.pf_instr_req_o), 32'h0);
    chk("rst_valid", 32'(bus.pf_valid_o), 32'h0);
    chk("rst_busy",  32'(bus.pf_busy_o), 32'h0);
    chk("rst_instr", bus.pf_instr_o, 32'h0);
    chk("rst_pc",    bus.pf_pc_o, BOOT);
    chk("rst_addr",  bus.pf_instr_addr_o, BOOT);
    @(posedge clk);
    #1;
  endtask

  // One clock: drive, check at the falling edge, advance the model at the rising edge.
  task automatic step(input bit fe, input bit rdy, input bit vld, input bit fl,
                      input logic [31:0] fpc, input bit pop);
    bit          v, er, ev, keep, had;
    logic [31:0] ei, ep;
    flight_t     e;
    v = vld && (infl.size() > 0);
    drive(fe, rdy, v, fl, fpc, pop);
    er = fe && !fl && ((fq.size() + infl.size()) < DEPTH);
    ev = 1'b0; ei = 32'h0; ep = 32'h0;
    if (fq.size() > 0) begin
      ev = 1'b1; ei = fq[0].instr; ep = fq[0].pc;
    end else if (BYP && v && !fl && !infl[0].disc) begin
      ev = 1'b1; ei = mem_data(infl[0].addr); ep = infl[0].addr;
    end
    @(negedge clk);
    chk("req",   32'(bus.pf_instr_req_o), 32'(er));
    chk("addr",  bus.pf_instr_addr_o, nxt);
    chk("busy",  32'(bus.pf_busy_o), 32'(infl.size() > 0));
    chk("valid", 32'(bus.pf_valid_o), 32'(ev));
    chk("instr", bus.pf_instr_o, ei);
    if (ev) chk("pc", bus.pf_pc_o, ep);
    if (bus.pf_valid_o && pop && !fl) begin
      chk("pop_seq", bus.pf_pc_o, pop_pc);
      pop_pc = pop_pc + 32'd4;
    end
    @(posedge clk);
    keep = 1'b0;
    e    = '{32'h0, 1'b0};
    if (v) begin
      e    = infl.pop_front();
      keep = !e.disc && !fl;
    end
    if (fl) begin
      fq.delete();
      foreach (infl[i]) infl[i].disc = 1'b1;
      nxt    = fpc & ~32'd3;
      pop_pc = fpc & ~32'd3;
    end else begin
      had = (fq.size() > 0);
      if (pop && had) void'(fq.pop_front());
      if (keep && !(BYP && !had && pop)) fq.push_back('{mem_data(e.addr), e.addr});
    end
    if (er && rdy) begin
      infl.push_back('{nxt, 1'b0});
      nxt = nxt + 32'd4;
    end
    #1;
  endtask

  initial begin
    logic [31:0] a0;

    do_reset();

    // Fill with no pops: four grants, then request drops with the head at 0x0.
    repeat (10) step(1, 1, 1, 0, 32'h0, 0);
    chk("fill_req",   32'(bus.pf_instr_req_o), 32'h0);
    chk("fill_valid", 32'(bus.pf_valid_o), 32'h1);
    chk("fill_pc",    bus.pf_pc_o, 32'h0);
    chk("fill_addr",  bus.pf_instr_addr_o, 32'h10);

    // Drain while refilling: pop every cycle.
    repeat (16) step(1, 1, 1, 0, 32'h0, 1);

    // Stall with ready low for three cycles, then grant.
    do_reset();
    a0 = bus.pf_instr_addr_o;
    repeat (3) step(1, 0, 0, 0, 32'h0, 0);
    chk("stall_addr", bus.pf_instr_addr_o, a0);
    chk("stall_busy", 32'(bus.pf_busy_o), 32'h0);
    step(1, 1, 0, 0, 32'h0, 0);
    chk("stall_grant_busy", 32'(bus.pf_busy_o), 32'h1);
    chk("stall_next_addr",  bus.pf_instr_addr_o, a0 + 32'd4);

    // Flush with two requests outstanding; the late responses are dropped.
    do_reset();
    repeat (2) step(1, 1, 0, 0, 32'h0, 0);
    step(1, 0, 0, 1, 32'h0000_0103, 0);
    chk("flush_addr", bus.pf_instr_addr_o, 32'h100);
    repeat (2) step(1, 0, 1, 0, 32'h0, 0);
    chk("flush_discard_valid", 32'(bus.pf_valid_o), 32'h0);
    repeat (4) step(1, 1, 1, 0, 32'h0, 0);
    chk("flush_pc", bus.pf_pc_o, 32'h100);
    repeat (4) step(1, 1, 1, 0, 32'h0, 1);

    // Reset with two requests in flight.
    repeat (2) step(1, 1, 0, 0, 32'h0, 0);
    do_reset();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7,
                $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0,
                $urandom, $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
